// File: rtl/hdmi_i2c_target.sv
// I2C target standing in for the HDMI transmitter's configuration port:
// 256x8 register file, W1C interrupt status at 0x96, enable at 0x94, active-low int_n.
module hdmi_i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       hpd_event,
  output logic       int_n,
  output logic       reg_wr_stb,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_ADDR_ACK, ST_REG_ADDR, ST_REG_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
  } state_t;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]    scl_sync, sda_sync;
  logic [1:0]    raw, filt, filt_d;
  logic [CW-1:0] flt_cnt [2];

  assign raw = {scl_sync[1], sda_sync[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      filt     <= 2'b11;
      filt_d   <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      filt_d   <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]    <= raw[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, bus_start, bus_stop;
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_d[1];
  assign scl_fall  = ~filt[1] & filt_d[1];
  // SCL must be steady high across the SDA transition to count as START/STOP
  assign bus_start = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
  assign bus_stop  = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, ptr, ptr_n, rd_shift, rd_shift_n;
  logic       ack_hold, ack_hold_n, rw, rw_n, sda_oe_n;
  logic       wr_stb_n;
  logic [7:0] wr_addr_n, wr_data_n, byte_in, rd_byte;
  logic [7:0] regs [256];

  assign byte_in = {shift[6:0], sda_f};
  assign rd_byte = regs[ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      ptr         <= 8'h00;
      rd_shift    <= 8'h00;
      ack_hold    <= 1'b0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 8'h00;
      reg_wr_data <= 8'h00;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      ptr         <= ptr_n;
      rd_shift    <= rd_shift_n;
      ack_hold    <= ack_hold_n;
      rw          <= rw_n;
      sda_oe      <= sda_oe_n;
      reg_wr_stb  <= wr_stb_n;
      reg_wr_addr <= wr_addr_n;
      reg_wr_data <= wr_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    ptr_n      = ptr;
    rd_shift_n = rd_shift;
    ack_hold_n = ack_hold;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    wr_stb_n   = 1'b0;
    wr_addr_n  = reg_wr_addr;
    wr_data_n  = reg_wr_data;
    if (bus_start) begin
      state_n    = ST_DEV_ADDR;
      bit_cnt_n  = 3'd0;
      ack_hold_n = 1'b0;
      sda_oe_n   = 1'b0;
    end else if (bus_stop) begin
      state_n    = ST_IDLE;
      ack_hold_n = 1'b0;
      sda_oe_n   = 1'b0;
    end else begin
      case (state)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_DEV_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_n = ST_ADDR_ACK;
                  rw_n    = byte_in[0];
                end else begin
                  state_n = ST_IDLE;
                end
              end else if (state == ST_REG_ADDR) begin
                ptr_n   = byte_in;
                state_n = ST_REG_ACK;
              end else begin
                wr_stb_n  = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = byte_in;
                ptr_n     = ptr + 8'd1;
                state_n   = ST_WR_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
          // first fall starts the ACK pulse, second fall ends the 9th clock
          if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe_n   = 1'b1;
              ack_hold_n = 1'b1;
            end else begin
              ack_hold_n = 1'b0;
              bit_cnt_n  = 3'd0;
              if (state == ST_ADDR_ACK && rw) begin
                state_n    = ST_RD_DATA;
                rd_shift_n = rd_byte;
                sda_oe_n   = ~rd_byte[7];
              end else begin
                sda_oe_n = 1'b0;
                state_n  = (state == ST_ADDR_ACK) ? ST_REG_ADDR : ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = ST_RD_ACK;
            end else begin
              sda_oe_n   = ~rd_shift[6];
              rd_shift_n = {rd_shift[6:0], 1'b0};
              bit_cnt_n  = bit_cnt + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_n      = ptr + 8'd1;
              ack_hold_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (scl_fall && ack_hold) begin
            ack_hold_n = 1'b0;
            rd_shift_n = rd_byte;
            sda_oe_n   = ~rd_byte[7];
            state_n    = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // The strobed write commits in the cycle reg_wr_stb is high, so an hpd_event
  // seen in that cycle lands together with a W1C clear and wins.
  logic [7:0] clr96, r96_n;
  assign clr96 = (reg_wr_stb && reg_wr_addr == 8'h96) ? reg_wr_data : 8'h00;
  assign r96_n = (regs[8'h96] & ~clr96) | {hpd_event, 7'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= (i == 'h94) ? 8'hC0 : 8'h00;
      int_n <= 1'b1;
    end else begin
      if (reg_wr_stb && reg_wr_addr != 8'h96) regs[reg_wr_addr] <= reg_wr_data;
      regs[8'h96] <= r96_n;
      int_n       <= ~|(regs[8'h96] & regs[8'h94]);
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Bench for hdmi_i2c_target: bit-level I2C master tasks, a transaction-level
// register-file model, and a per-cycle monitor for write strobes and bus silence.
module tb_hdmi_i2c_target;

  localparam int Q = 12;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, hpd_event, int_n;
  logic       reg_wr_stb;
  logic [7:0] reg_wr_addr, reg_wr_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  mdl_regs [256];
  logic [7:0]  mdl_ptr;
  bit          silent = 1'b0;
  bit          hpd_req = 1'b0, hpd_on_stb = 1'b0, hpd_fired = 1'b0;

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;  // open-drain wired-AND

  hdmi_i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .hpd_event(hpd_event), .int_n(int_n), .reg_wr_stb(reg_wr_stb),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic mdl_reset();
    for (int i = 0; i < 256; i++) mdl_regs[i] = 8'h00;
    mdl_regs[8'h94] = 8'hC0;
    mdl_ptr = 8'h00;
  endtask

  function automatic logic mdl_int();
    return ~|(mdl_regs[8'h96] & mdl_regs[8'h94]);
  endfunction

  task automatic mdl_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h96) mdl_regs[a] = mdl_regs[a] & ~d;
    else mdl_regs[a] = d;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr_stb) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_stb_unexpected actual addr=0x%0h data=0x%0h required=no strobe",
                   reg_wr_addr, reg_wr_data);
        end else begin
          check("wr_stb_addr_data", {reg_wr_addr, reg_wr_data}, exp_q.pop_front());
        end
      end
      if (silent) check("sda_oe_silent", sda_oe, 1'b0);
    end
  end

  // hpd_event driver: manual pulse request, or one pulse aligned to the next strobe
  always @(negedge clk) begin
    if (hpd_on_stb && reg_wr_stb) begin
      hpd_event  = 1'b1;
      hpd_fired  = 1'b1;
      hpd_on_stb = 1'b0;
    end else if (hpd_req) begin
      hpd_event = 1'b1;
      hpd_req   = 1'b0;
    end else begin
      hpd_event = 1'b0;
    end
  end

  // ---------------- bus driver ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_in;   wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      d[i] = bt;
    end
    write_bit(nack);
  endtask

  // START, device byte, register byte, n data bytes, optional STOP
  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] ra,
                        input logic [7:0] d [4], input int n, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (dev[7:1] == 7'h39) && !dev[0];
    i2c_start();
    write_byte(dev, ack);
    check("dev_addr_ack", ack, hit ? 1'b0 : 1'b1);
    write_byte(ra, ack);
    check("reg_addr_ack", ack, hit ? 1'b0 : 1'b1);
    if (hit) mdl_ptr = ra;
    for (int k = 0; k < n; k++) begin
      if (hit) begin
        exp_q.push_back({mdl_ptr, d[k]});
        mdl_write(mdl_ptr, d[k]);
        mdl_ptr = mdl_ptr + 8'd1;
      end
      write_byte(d[k], ack);
      check("data_ack", ack, hit ? 1'b0 : 1'b1);
    end
    if (do_stop) i2c_stop();
  endtask

  // (repeated) START, 0x73, n bytes ACKed except the last, then STOP
  task automatic rd_txn(input int n, output logic [7:0] got [4]);
    logic ack;
    for (int k = 0; k < 4; k++) got[k] = 8'h00;
    i2c_start();
    write_byte(8'h73, ack);
    check("rd_dev_ack", ack, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte(got[k], (k == n - 1));
      check("rd_data_model", got[k], mdl_regs[mdl_ptr]);
      if (k != n - 1) mdl_ptr = mdl_ptr + 8'd1;
    end
    wait_clk(Q);
    check("rd_released_after_nack", sda_oe, 1'b0);
    i2c_stop();
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    logic [7:0] nod [4];
    logic [7:0] got [4];
    nod = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h72, a, nod, 0, 1'b0);
    rd_txn(1, got);
    v = got[0];
  endtask

  task automatic pulse_hpd();
    hpd_req = 1'b1;
    wait_clk(3);
    mdl_regs[8'h96] = mdl_regs[8'h96] | 8'h80;
    wait_clk(4);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] v;
    logic       ack;

    hpd_event = 1'b0;
    mdl_reset();
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_int_n", int_n, 1'b1);
    check("reset_wr_stb", reg_wr_stb, 1'b0);
    check("reset_wr_addr", reg_wr_addr, 8'h00);
    check("reset_wr_data", reg_wr_data, 8'h00);
    rd_reg(8'h94, v);
    check("reset_reg94", v, 8'hC0);

    // address mismatch: bus untouched, nothing written
    d = '{8'h03, 8'h00, 8'h00, 8'h00};
    silent = 1'b1;
    wr_txn(8'h70, 8'h98, d, 1, 1'b1);
    silent = 1'b0;
    rd_reg(8'h98, v);
    check("mismatch_reg98", v, 8'h00);

    // single write
    wr_txn(8'h72, 8'h98, d, 1, 1'b1);
    check("single_wr_last_addr", reg_wr_addr, 8'h98);
    check("single_wr_last_data", reg_wr_data, 8'h03);
    rd_reg(8'h98, v);
    check("single_readback", v, 8'h03);

    // burst with pointer wrap, then read across the wrap
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    wr_txn(8'h72, 8'hFE, d, 3, 1'b1);
    check("burst_last_addr", reg_wr_addr, 8'h00);
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h72, 8'hFF, d, 0, 1'b0);
    rd_txn(2, got);
    check("wrap_read_ff", got[0], 8'h22);
    check("wrap_read_00", got[1], 8'h33);

    // repeated-start read of two bytes
    d = '{8'h20, 8'h30, 8'h00, 8'h00};
    wr_txn(8'h72, 8'h15, d, 2, 1'b1);
    wr_txn(8'h72, 8'h15, d, 0, 1'b0);
    rd_txn(2, got);
    check("sr_read_15", got[0], 8'h20);
    check("sr_read_16", got[1], 8'h30);

    // interrupt set / W1C clear / coincident set-wins
    pulse_hpd();
    check("int_after_hpd_model", int_n, mdl_int());
    check("int_after_hpd", int_n, 1'b0);
    d = '{8'hF6, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h72, 8'h96, d, 1, 1'b1);
    check("int_after_w1c_model", int_n, mdl_int());
    check("int_after_w1c", int_n, 1'b1);
    pulse_hpd();
    check("int_rearmed", int_n, 1'b0);
    hpd_fired = 1'b0;
    hpd_on_stb = 1'b1;
    wr_txn(8'h72, 8'h96, d, 1, 1'b1);
    hpd_on_stb = 1'b0;
    mdl_regs[8'h96] = mdl_regs[8'h96] | 8'h80;
    check("hpd_coincident_fired", hpd_fired, 1'b1);
    check("int_set_wins_model", int_n, mdl_int());
    check("int_set_wins", int_n, 1'b0);
    rd_reg(8'h96, v);
    check("reg96_set_wins", v, 8'h80);

    // reset while the target drives a 0 bit of reg[0x15] = 0x20
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h72, 8'h15, d, 0, 1'b0);
    i2c_start();
    write_byte(8'h73, ack);
    check("midread_dev_ack", ack, 1'b0);
    check("midread_driving_zero", sda_oe, 1'b1);
    check("midread_int_before", int_n, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midread_reset_sda_oe", sda_oe, 1'b0);
    check("midread_reset_int_n", int_n, 1'b1);
    wait_clk(3);
    reset = 1'b0;
    mdl_reset();
    wait_clk(2);
    i2c_stop();
    rd_reg(8'h15, v);
    check("post_reset_reg15", v, 8'h00);

    wait_clk(4);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=sequence complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hdmi_i2c_target.md
# hdmi_i2c_target

I2C target (responder) that emulates the HDMI transmitter's configuration register port. It answers the HDMI I2C configuration master at 7-bit address 0x39, which appears as write byte 0x72 and read byte 0x73, and holds a 256×8 register file. Interrupt status and enable registers drive an active-low interrupt line back to the master, which lets the full configuration loop be closed in simulation or on a loopback board. The block sits on the SCL/SDA pins in place of the transmitter device.

## Interface
- DEV_ADDR, 7'h39, 7-bit target address.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before SCL/SDA change their filtered value.
- clk  in  1  system clock; must run at ≥ 20× the SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  SCL pin level; the block never drives SCL (no clock stretching).
- sda_in  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA. Reset value 0.
- hpd_event  in  1  one-clk pulse that sets status bit reg[0x96][7].
- int_n  out  1  interrupt, active low: int_n = ~|(reg[0x96] & reg[0x94]). Reset value 1.
- reg_wr_stb  out  1  one-clk pulse per accepted data byte. Reset value 0.
- reg_wr_addr  out  8  register index of the last accepted write. Reset value 0x00.
- reg_wr_data  out  8  data byte of the last accepted write. Reset value 0x00.

## Operation
- Input conditioning:
  - scl_in and sda_in pass through a 2-flop synchronizer, then a FILTER_LEN-sample stability filter.
  - Edge detection runs on the filtered values. The filtered values reset to 1.
- Bus events:
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - A START in any state, including a repeated START, clears the bit counter and enters DEV_ADDR. The register pointer is preserved.
  - A STOP in any state enters IDLE and releases sda_oe.
- FSM states: IDLE, DEV_ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- Bit transfer: incoming bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall.
- DEV_ADDR:
  - After 8 bits, if byte[7:1] == DEV_ADDR, go to ADDR_ACK. The next state is REG_ADDR if R/W = 0, or RD_DATA if R/W = 1.
  - On mismatch, go to IDLE with no ACK and ignore the bus until the next START.
- ACK driving: sda_oe = 1 from the SCL fall after the 8th bit until the following SCL fall (the 9th clock).
- REG_ADDR: the byte is loaded into the 8-bit pointer, then always ACKed via REG_ACK, then the FSM goes to WR_DATA.
- WR_DATA:
  - Each byte is written to reg[ptr] on the 8th SCL rise, and reg_wr_stb pulses.
  - The byte is ACKed via WR_ACK.
  - ptr increments with wrap-around from 0xFF to 0x00.
- RD_DATA:
  - reg[ptr] is latched into a shift register at the ACK-ending SCL fall.
  - sda_oe = ~bit, MSB first, presented on each SCL fall.
  - After 8 bits, sda_oe is released and the master's bit is sampled on the 9th SCL rise (RD_ACK).
  - ACK (0): ptr++ (wraps) and the next byte is sent.
  - NACK (1): go to IDLE.
- Register file:
  - All registers reset to 0x00, except reg[0x94] = 0xC0.
  - reg[0x96] is write-1-to-clear: new = old & ~data.
  - hpd_event sets bit 7 of reg[0x96]. If a set and a clear of the same bit happen in the same cycle, the set wins.
  - Reads return the stored values.
- Reset mid-transaction: sda_oe is released immediately (asynchronously), the FSM goes to IDLE, and the register file returns to its reset values.

## Timing
- Input latency: 2 sync flops + FILTER_LEN samples from pin change to a detected edge, giving 5 clk with the defaults.
- reg_wr_stb is asserted 1 clk after the detected 8th SCL rise of a data byte. reg_wr_addr and reg_wr_data are valid in the same cycle and hold until the next write.
- sda_oe updates 1 clk after a detected SCL fall.
- int_n is registered and updates 1 clk after a change to reg[0x96] or reg[0x94].
- A hpd_event and a W1C write landing in the same clk resolve as set-wins in that clk.

## Test plan
- Single write: START, 0x72, 0x98, 0x03, STOP → ACK on all 3 bytes; one reg_wr_stb with addr = 0x98, data = 0x03; a readback of reg[0x98] returns 0x03.
- Address mismatch: START, 0x70, 0x98, 0x03, STOP → sda_oe stays 0 throughout; no reg_wr_stb; reg[0x98] unchanged.
- Burst with wrap: START, 0x72, 0xFE, 0x11, 0x22, 0x33, STOP → writes reg[0xFE] = 0x11, reg[0xFF] = 0x22, reg[0x00] = 0x33; 3 strobes.
- Repeated-start read: write ptr 0x15 (after a prior write of 0x20 to reg[0x15] and 0x30 to reg[0x16]), then Sr, 0x73; read two bytes with ACK then NACK → SDA returns 0x20 then 0x30; block in IDLE with sda_oe = 0 after the NACK.
- Interrupt: pulse hpd_event → int_n goes 0 (reg[0x94] = 0xC0); write 0x72, 0x96, 0xF6 → int_n returns to 1. hpd_event coincident with that write → int_n stays 0.
- Reset mid-read: assert reset while the target is driving a 0 bit → sda_oe = 0 the same cycle, int_n = 1, reg[0x15] reads back 0x00 after release.
